// File: rtl/imem_pipe_if.sv
// Fetch, response and program-load signals of imem_pipe, bundled as one interface.
interface imem_pipe_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [31:0] rsp_addr;
  logic [1:0]  rsp_fault;
  logic        ld_en;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;

  modport master (
    output req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data,
    input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_fault
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data,
    output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_fault
  );
endinterface

// File: rtl/imem_pipe.sv
// Instruction memory: synchronous read into stage S1, then a two-entry in-order
// response queue. Misaligned / out-of-range fetches return FAULT_WORD with a code.
module imem_pipe #(
  parameter int          DEPTH      = 64,
  parameter string       INIT_FILE  = "imem.mem",
  parameter logic [31:0] FAULT_WORD = 32'h00000013
) (
  input logic        clk,
  input logic        reset,
  imem_pipe_if.slave bus
);

  localparam int         AW    = $clog2(DEPTH);
  localparam logic [1:0] F_OK  = 2'b00;
  localparam logic [1:0] F_MIS = 2'b01;
  localparam logic [1:0] F_OOR = 2'b10;

  function automatic logic [1:0] fault_code(input logic [31:0] addr);
    if (addr[1:0] != 2'b00) begin
      return F_MIS;
    end else if ((addr >> (AW + 2)) != 32'd0) begin
      return F_OOR;
    end else begin
      return F_OK;
    end
  endfunction

  logic [31:0] mem_r [DEPTH];

  logic        s1_valid_r;
  logic [31:0] s1_data_r;
  logic [31:0] s1_addr_r;
  logic [1:0]  s1_fault_r;

  logic [31:0] q_data_r  [2];
  logic [31:0] q_addr_r  [2];
  logic [1:0]  q_fault_r [2];
  logic [1:0]  q_cnt_r;

  logic [1:0]    occ_s;
  logic          accept_s;
  logic          rsp_valid_s;
  logic          pop_s;
  logic          qpop_s;
  logic          push_s;
  logic [1:0]    slot_s;
  logic          q_empty_s;
  logic [1:0]    req_fault_s;
  logic [1:0]    ld_fault_s;
  logic [AW-1:0] req_idx_s;
  logic [AW-1:0] ld_idx_s;

  // Handshake and queue control, all derived from registered occupancy.
  always_comb begin
    q_empty_s   = (q_cnt_r == 2'd0);
    occ_s       = q_cnt_r + {1'b0, s1_valid_r};
    accept_s    = bus.req_valid && (occ_s < 2'd2);
    rsp_valid_s = !q_empty_s || s1_valid_r;
    pop_s       = rsp_valid_s && bus.rsp_ready;
    qpop_s      = pop_s && !q_empty_s;
    // S1 leaves every edge: consumed directly when it is the head, else queued.
    push_s      = s1_valid_r && !(pop_s && q_empty_s);
    slot_s      = q_cnt_r - {1'b0, qpop_s};
    req_fault_s = fault_code(bus.req_addr);
    ld_fault_s  = fault_code(bus.ld_addr);
    req_idx_s   = bus.req_addr[AW+1:2];
    ld_idx_s    = bus.ld_addr[AW+1:2];
  end

  assign bus.req_ready = (occ_s < 2'd2);
  assign bus.rsp_valid = rsp_valid_s;
  assign bus.rsp_data  = q_empty_s ? s1_data_r  : q_data_r[0];
  assign bus.rsp_addr  = q_empty_s ? s1_addr_r  : q_addr_r[0];
  assign bus.rsp_fault = q_empty_s ? s1_fault_r : q_fault_r[0];

  // Program-load port; illegal addresses are dropped.
  always_ff @(posedge clk) begin
    if (bus.ld_en && (ld_fault_s == F_OK)) begin
      mem_r[ld_idx_s] <= bus.ld_data;
    end
  end

  // S1: registered array read (read-first against a same-edge load).
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= 32'd0;
      s1_addr_r  <= 32'd0;
      s1_fault_r <= F_OK;
    end else begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_addr_r  <= bus.req_addr;
        s1_fault_r <= req_fault_s;
        s1_data_r  <= (req_fault_s == F_OK) ? mem_r[req_idx_s] : FAULT_WORD;
      end
    end
  end

  // Two-entry response queue; entry 0 is the head.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_cnt_r <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        q_data_r[i]  <= 32'd0;
        q_addr_r[i]  <= 32'd0;
        q_fault_r[i] <= F_OK;
      end
    end else begin
      if (qpop_s) begin
        q_data_r[0]  <= q_data_r[1];
        q_addr_r[0]  <= q_addr_r[1];
        q_fault_r[0] <= q_fault_r[1];
      end
      if (push_s) begin
        q_data_r[slot_s[0]]  <= s1_data_r;
        q_addr_r[slot_s[0]]  <= s1_addr_r;
        q_fault_r[slot_s[0]] <= s1_fault_r;
      end
      q_cnt_r <= q_cnt_r + {1'b0, push_s} - {1'b0, qpop_s};
    end
  end

endmodule

// File: tb/tb_imem_pipe.sv
// Scoreboard bench for imem_pipe: stimulus pushes expected responses, a monitor
// on the falling edge pops and compares whatever the DUT presents.
module tb_imem_pipe;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   lat_chk = 1'b0;

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
    logic [1:0]  fault;
    int          acc;
    bit          lat;
    bit          seen;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_mem [64];

  imem_pipe_if bus ();

  imem_pipe #(.DEPTH(64), .INIT_FILE(""), .FAULT_WORD(32'h00000013)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] d, input logic [1:0] f);
    exp_t e;
    e.data = d;
    e.addr = a;
    e.fault = f;
    e.acc = cyc + 1;
    e.lat = lat_chk;
    e.seen = 1'b0;
    sb.push_back(e);
  endtask

  // Reference fetch result: misaligned first, then range, else memory word.
  task automatic push_model(input logic [31:0] a);
    if (a[1:0] != 2'b00) push_exp(a, 32'h00000013, 2'b01);
    else if (a >= 32'd256) push_exp(a, 32'h00000013, 2'b10);
    else push_exp(a, exp_mem[a[7:2]], 2'b00);
  endtask

  task automatic model_load(input logic [31:0] a, input logic [31:0] d);
    if (a[1:0] == 2'b00 && a < 32'd256) exp_mem[a[7:2]] = d;
  endtask

  task automatic issue_exp(input logic [31:0] a, input logic [31:0] d, input logic [1:0] f,
                           input bit use_model);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    for (int n = 0; n < 50 && !bus.req_ready; n++) tick();
    check("accept_timeout", {31'd0, bus.req_ready}, 32'd1);
    if (bus.req_ready) begin
      if (use_model) push_model(a);
      else push_exp(a, d, f);
    end
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    bus.rsp_ready = 1'b1;
    for (int n = 0; n < 100 && sb.size() != 0; n++) tick();
    check("drain_left", sb.size(), 32'd0);
  endtask

  // Monitor: every presented response must match the head of the scoreboard.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset && bus.rsp_valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_rsp: got valid with data=%h addr=%h, expected no response",
                 bus.rsp_data, bus.rsp_addr);
      end else begin
        e = sb[0];
        tests++;
        if (bus.rsp_data !== e.data || bus.rsp_addr !== e.addr || bus.rsp_fault !== e.fault) begin
          fails++;
          $display("FAIL rsp: got data=%h addr=%h fault=%b expected data=%h addr=%h fault=%b",
                   bus.rsp_data, bus.rsp_addr, bus.rsp_fault, e.data, e.addr, e.fault);
        end
        if (e.lat && !e.seen) begin
          check("latency_cycle", cyc, e.acc);
          e.seen = 1'b1;
          sb[0] = e;
        end
        if (bus.rsp_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic [31:0] old_w;
    int          r;
    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = 32'd0;
    bus.rsp_ready = 1'b1;
    bus.ld_en     = 1'b0;
    bus.ld_addr   = 32'd0;
    bus.ld_data   = 32'd0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_data", bus.rsp_data, 32'd0);
    check("rst_rsp_addr", bus.rsp_addr, 32'd0);
    check("rst_rsp_fault", {30'd0, bus.rsp_fault}, 32'd0);
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);

    // Program image through the load port, then two illegal loads that must be dropped.
    for (int i = 0; i < 64; i++) begin
      bus.ld_en   = 1'b1;
      bus.ld_addr = 32'(i) << 2;
      bus.ld_data = 32'hC0DE0000 + 32'(i) * 32'h00000101;
      model_load(bus.ld_addr, bus.ld_data);
      tick();
    end
    bus.ld_addr = 32'h00000012; bus.ld_data = 32'hBAD00001; tick();
    bus.ld_addr = 32'h00000104; bus.ld_data = 32'hBAD00002; tick();
    bus.ld_en = 1'b0;

    // Streaming with one-cycle latency check.
    lat_chk = 1'b1;
    for (int i = 0; i < 64; i++) issue_exp(32'(i) << 2, 32'd0, 2'b00, 1'b1);
    lat_chk = 1'b0;
    drain();

    // Faults with hand-written expectations.
    issue_exp(32'h00000006, 32'h00000013, 2'b01, 1'b0);
    issue_exp(32'h00000100, 32'h00000013, 2'b10, 1'b0);
    issue_exp(32'h00000106, 32'h00000013, 2'b01, 1'b0);
    issue_exp(32'h00000008, 32'hC0DE0202, 2'b00, 1'b0);
    drain();

    // Backpressure: only two requests fit while the consumer stalls.
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0;
    check("bp_ready0", {31'd0, bus.req_ready}, 32'd1);
    push_model(32'h0);
    tick();
    bus.req_addr = 32'h4;
    check("bp_ready1", {31'd0, bus.req_ready}, 32'd1);
    push_model(32'h4);
    tick();
    bus.req_addr = 32'h8;
    check("bp_ready2", {31'd0, bus.req_ready}, 32'd0);
    tick();
    tick();
    check("bp_ready_hold", {31'd0, bus.req_ready}, 32'd0);
    check("bp_rsp_hold", bus.rsp_addr, 32'h0);
    bus.rsp_ready = 1'b1;
    tick();
    check("bp_ready_after_pop", {31'd0, bus.req_ready}, 32'd1);
    if (bus.req_ready) push_model(32'h8);
    tick();
    bus.req_valid = 1'b0;
    drain();

    // Load/fetch collision on word 4: old word now, new word next fetch.
    old_w = exp_mem[4];
    bus.ld_en   = 1'b1;
    bus.ld_addr = 32'h10;
    bus.ld_data = 32'hDEADBEEF;
    issue_exp(32'h10, old_w, 2'b00, 1'b0);
    bus.ld_en = 1'b0;
    model_load(32'h10, 32'hDEADBEEF);
    issue_exp(32'h10, 32'hDEADBEEF, 2'b00, 1'b0);
    drain();

    // Reset with two buffered responses and a request held during reset.
    bus.rsp_ready = 1'b0;
    issue_exp(32'h20, 32'd0, 2'b00, 1'b1);
    issue_exp(32'h24, 32'd0, 2'b00, 1'b1);
    check("mid_ready_full", {31'd0, bus.req_ready}, 32'd0);
    reset = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h28;
    tick();
    reset = 1'b0;
    bus.req_valid = 1'b0;
    sb.delete();
    check("mid_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("mid_req_ready", {31'd0, bus.req_ready}, 32'd1);
    bus.rsp_ready = 1'b1;
    tick();
    tick();
    check("mid_no_stale", {31'd0, bus.rsp_valid}, 32'd0);
    issue_exp(32'h10, 32'hDEADBEEF, 2'b00, 1'b0);
    drain();

    // Random traffic with interleaved loads.
    for (int n = 0; n < 10000; n++) begin
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      bus.req_valid = ($urandom_range(0, 1) != 0);
      r = $urandom_range(0, 9);
      if (r < 7) a = 32'($urandom_range(0, 63)) << 2;
      else if (r == 7) a = (32'($urandom_range(0, 127)) << 2) | 32'($urandom_range(1, 3));
      else a = 32'd256 + (32'($urandom_range(0, 1023)) << 2);
      bus.req_addr = a;
      bus.ld_en    = ($urandom_range(0, 15) == 0);
      bus.ld_addr  = (32'($urandom_range(0, 80)) << 2) | 32'($urandom_range(0, 3) == 0 ? 1 : 0);
      bus.ld_data  = $urandom;
      if (bus.req_valid && bus.req_ready) push_model(a);
      if (bus.ld_en) model_load(bus.ld_addr, bus.ld_data);
      tick();
    end
    bus.req_valid = 1'b0;
    bus.ld_en     = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
